// File: rtl/conv1d_window_feeder_if.sv
// rtl/conv1d_window_feeder_if.sv - sample-in / window-out handshake bundle for the conv1d window feeder
// master = stream source and window consumer, slave = the feeder itself.
interface conv1d_window_feeder_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [BIT_WIDTH-1:0] window_0;
  logic [BIT_WIDTH-1:0] window_1;
  logic [BIT_WIDTH-1:0] window_2;
  logic [BIT_WIDTH-1:0] window_3;
  logic [BIT_WIDTH-1:0] window_4;
  logic [BIT_WIDTH-1:0] window_5;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_last,
    input  window_0, window_1, window_2, window_3, window_4, window_5
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_last,
    output window_0, window_1, window_2, window_3, window_4, window_5
  );
endinterface

// File: rtl/conv1d_window_feeder.sv
// rtl/conv1d_window_feeder.sv - fans a serial sample stream out to 6-lane windows with stride and framing
// Build option: define ZERO_PAD_EN for causal zero padding (first window on the first sample of each frame).
module conv1d_window_feeder #(
  parameter int BIT_WIDTH = 32,
  parameter int SEQ_LEN   = 256,
  parameter int STRIDE    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv1d_window_feeder_if.slave  bus_io
);

`ifdef ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  localparam int FILL_LAST = ZERO_PAD ? 0 : 5;
  localparam int NUM_WIN   = ZERO_PAD ? (SEQ_LEN - 1) / STRIDE + 1
                                      : (SEQ_LEN - 6) / STRIDE + 1;
  // Sample index whose acceptance completes the final window of a frame.
  localparam int LAST_S    = FILL_LAST + (NUM_WIN - 1) * STRIDE;
  localparam int SW        = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int PW        = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [PW-1:0]        p_q, p_d;
  logic [BIT_WIDTH-1:0] sr_q  [6];
  logic [BIT_WIDTH-1:0] sr_d  [6];
  logic [BIT_WIDTH-1:0] win_q [6];
  logic [BIT_WIDTH-1:0] win_d [6];
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;

  logic                 in_ready;
  logic                 accept;
  logic                 emit;
  logic                 frame_end;
  logic [PW-1:0]        p_next;
  logic [BIT_WIDTH-1:0] base    [6];
  logic [BIT_WIDTH-1:0] shifted [6];

  // A window can only be emitted on an accepted sample, so this also
  // guarantees an unconsumed window is never overwritten.
  assign in_ready  = !out_valid_q || bus_io.out_ready;
  assign accept    = bus_io.in_valid && in_ready;
  assign frame_end = (s_q == SW'(SEQ_LEN - 1));

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      base[k] = sr_q[k];
    end
    if (ZERO_PAD && (s_q == '0)) begin
      for (int k = 0; k < 6; k++) begin
        base[k] = '0;
      end
    end
    for (int k = 0; k < 5; k++) begin
      shifted[k] = base[k + 1];
    end
    shifted[5] = bus_io.in_data;
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    emit        = 1'b0;
    p_next      = p_q;
    for (int k = 0; k < 6; k++) begin
      sr_d[k]  = sr_q[k];
      win_d[k] = win_q[k];
    end

    if (out_valid_q && bus_io.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept) begin
      for (int k = 0; k < 6; k++) begin
        sr_d[k] = shifted[k];
      end
      s_d = frame_end ? '0 : s_q + SW'(1);

      unique case (state_q)
        ST_FILL: begin
          if (s_q == SW'(FILL_LAST)) begin
            emit    = 1'b1;
            p_d     = '0;
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          p_next = (p_q == PW'(STRIDE - 1)) ? '0 : p_q + PW'(1);
          p_d    = p_next;
          if (p_next == '0) begin
            emit = 1'b1;
          end
        end
        default: state_d = ST_FILL;
      endcase

      // Frame end wins over the FILL->STREAM move (matters when SEQ_LEN == 6).
      if (frame_end) begin
        state_d = ST_FILL;
      end
    end

    if (emit) begin
      for (int k = 0; k < 6; k++) begin
        win_d[k] = shifted[k];
      end
      out_valid_d = 1'b1;
      out_last_d  = (s_q == SW'(LAST_S));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      s_q         <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        sr_q[k]  <= '0;
        win_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      for (int k = 0; k < 6; k++) begin
        sr_q[k]  <= sr_d[k];
        win_q[k] <= win_d[k];
      end
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_last  = out_last_q;
  assign bus_io.window_0  = win_q[0];
  assign bus_io.window_1  = win_q[1];
  assign bus_io.window_2  = win_q[2];
  assign bus_io.window_3  = win_q[3];
  assign bus_io.window_4  = win_q[4];
  assign bus_io.window_5  = win_q[5];

endmodule

// File: tb/tb_conv1d_window_feeder.sv
// tb/tb_conv1d_window_feeder.sv - directed self-checking bench for conv1d_window_feeder (Seq_len=10, Stride 1 and 3)
module tb_conv1d_window_feeder;
  localparam int BW = 32;
  localparam int SL = 10;
`ifdef ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv1d_window_feeder_if #(.BIT_WIDTH(BW)) if_s1 ();
  conv1d_window_feeder_if #(.BIT_WIDTH(BW)) if_s3 ();

  conv1d_window_feeder #(.BIT_WIDTH(BW), .SEQ_LEN(SL), .STRIDE(1)) u_s1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if_s1.slave)
  );

  conv1d_window_feeder #(.BIT_WIDTH(BW), .SEQ_LEN(SL), .STRIDE(3)) u_s3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if_s3.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [BW-1:0] ow [6];
  logic          ov, ol, ori;
  logic [BW-1:0] vals [10];

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [BW-1:0] d, input logic ordy);
    if (sel == 1) begin
      if_s1.in_valid = v; if_s1.in_data = d; if_s1.out_ready = ordy;
    end else begin
      if_s3.in_valid = v; if_s3.in_data = d; if_s3.out_ready = ordy;
    end
  endtask

  task automatic observe(input int sel);
    if (sel == 1) begin
      ow[0] = if_s1.window_0; ow[1] = if_s1.window_1; ow[2] = if_s1.window_2;
      ow[3] = if_s1.window_3; ow[4] = if_s1.window_4; ow[5] = if_s1.window_5;
      ov = if_s1.out_valid; ol = if_s1.out_last; ori = if_s1.in_ready;
    end else begin
      ow[0] = if_s3.window_0; ow[1] = if_s3.window_1; ow[2] = if_s3.window_2;
      ow[3] = if_s3.window_3; ow[4] = if_s3.window_4; ow[5] = if_s3.window_5;
      ov = if_s3.out_valid; ol = if_s3.out_last; ori = if_s3.in_ready;
    end
  endtask

  task automatic chk_zero(input int sel, input string tag);
    observe(sel);
    chk({tag, ".out_valid"}, {31'd0, ov}, 32'd0);
    chk({tag, ".out_last"}, {31'd0, ol}, 32'd0);
    chk({tag, ".in_ready"}, {31'd0, ori}, 32'd1);
    for (int k = 0; k < 6; k++) chk($sformatf("%s.window_%0d", tag, k), ow[k], 32'd0);
  endtask

  // Expected outputs one cycle after accepting local sample n (1-based) of a 10-sample frame.
  task automatic check_after(input int sel, input int stride, input int n,
                             input logic [BW-1:0] fv [10], input string tag);
    logic exp_v, exp_l;
    int   last_n, idx;
    if (ZP) begin
      exp_v  = ((n - 1) % stride) == 0;
      last_n = 1 + ((SL - 1) / stride) * stride;
    end else begin
      exp_v  = (n >= 6) && (((n - 6) % stride) == 0);
      last_n = 6 + ((SL - 6) / stride) * stride;
    end
    exp_l = exp_v && (n == last_n);
    observe(sel);
    chk($sformatf("%s.n%0d.out_valid", tag, n), {31'd0, ov}, {31'd0, exp_v});
    chk($sformatf("%s.n%0d.out_last", tag, n), {31'd0, ol}, {31'd0, exp_l});
    if (exp_v) begin
      for (int k = 0; k < 6; k++) begin
        idx = n - 6 + k;
        chk($sformatf("%s.n%0d.window_%0d", tag, n, k), ow[k], (idx >= 0) ? fv[idx] : 32'd0);
      end
    end
  endtask

  task automatic run_frame(input int sel, input int stride, input logic [BW-1:0] fv [10], input string tag);
    for (int n = 1; n <= SL; n++) begin
      drive(sel, 1'b1, fv[n-1], 1'b1);
      @(posedge clk); #1;
      check_after(sel, stride, n, fv, tag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 1'b0, '0, 1'b1);
    drive(3, 1'b0, '0, 1'b1);
    #12;
    chk_zero(1, "reset_s1");
    chk_zero(3, "reset_s3");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Stride 1, samples 1..10
    for (int i = 0; i < 10; i++) vals[i] = BW'(i + 1);
    run_frame(1, 1, vals, "s1_basic");
    drive(1, 1'b0, '0, 1'b1);
    @(posedge clk); #1;
    observe(1);
    chk("s1_basic.drained", {31'd0, ov}, 32'd0);

    // Stride 3, two back-to-back frames with no bubble
    run_frame(3, 3, vals, "s3_f1");
    for (int i = 0; i < 10; i++) vals[i] = BW'(i + 11);
    run_frame(3, 3, vals, "s3_f2");
    drive(3, 1'b0, '0, 1'b1);

    // Backpressure: hold the window covering samples 1..6 for four cycles
    for (int i = 0; i < 10; i++) vals[i] = BW'(i + 1);
    for (int n = 1; n <= 6; n++) begin
      drive(1, 1'b1, vals[n-1], 1'b1);
      @(posedge clk); #1;
      check_after(1, 1, n, vals, "bp");
    end
    drive(1, 1'b1, vals[6], 1'b0);
    #1;
    observe(1);
    chk("bp.in_ready_low", {31'd0, ori}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      observe(1);
      chk($sformatf("bp.hold%0d.in_ready", c), {31'd0, ori}, 32'd0);
      check_after(1, 1, 6, vals, $sformatf("bp.hold%0d", c));
    end
    drive(1, 1'b1, vals[6], 1'b1);
    @(posedge clk); #1;
    check_after(1, 1, 7, vals, "bp.release");
    for (int n = 8; n <= SL; n++) begin
      drive(1, 1'b1, vals[n-1], 1'b1);
      @(posedge clk); #1;
      check_after(1, 1, n, vals, "bp");
    end

    // Bit-exact pass-through of sign-heavy patterns
    vals[0] = 32'hFFFFFF00;
    vals[1] = 32'h80000000;
    for (int i = 2; i < 10; i++) vals[i] = BW'(i + 1);
    run_frame(1, 1, vals, "bitexact");

    // Reset after 3 samples of a frame clears outputs without a clock edge
    for (int i = 0; i < 10; i++) vals[i] = BW'(i + 1);
    for (int n = 1; n <= 3; n++) begin
      drive(1, 1'b1, vals[n-1], 1'b1);
      @(posedge clk); #1;
      check_after(1, 1, n, vals, "pre_rst");
    end
    drive(1, 1'b0, '0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_zero(1, "async_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1, 1, vals, "post_rst");
    drive(1, 1'b0, '0, 1'b1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
